// File: rtl/fir_xifu_ctrl.sv
// FIR XIFU instruction-ID scoreboard and controller.
// Each X-interface instruction ID owns one slot that walks
// FREE -> ISSUED -> COMMITTED/KILLED -> FREE. The slot states are decoded
// into the per-ID vectors seen by EX (commit permission) and WB (issued,
// committed and killed). Illegal handshakes raise a sticky error flag and
// leave the affected slot untouched.
module fir_xifu_ctrl #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned X_ID_MAX   = 2**X_ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  output logic                  issue_ready_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic [X_ID_MAX-1:0]   clear_i,
  output logic [X_ID_MAX-1:0]   ex_commit_o,
  output logic [X_ID_MAX-1:0]   wb_issue_o,
  output logic [X_ID_MAX-1:0]   wb_commit_o,
  output logic [X_ID_MAX-1:0]   wb_kill_o,
  output logic                  busy_o,
  output logic [X_ID_WIDTH:0]   outstanding_o,
  output logic                  err_o
);

  localparam logic [1:0] ST_FREE      = 2'd0;
  localparam logic [1:0] ST_ISSUED    = 2'd1;
  localparam logic [1:0] ST_COMMITTED = 2'd2;
  localparam logic [1:0] ST_KILLED    = 2'd3;

  logic [1:0]          state_q [X_ID_MAX];
  logic [1:0]          state_d [X_ID_MAX];
  logic [X_ID_MAX-1:0] err_slot;
  logic                err_q;
  logic                err_d;
  logic                issue_hit;
  logic                commit_hit;
  logic                clear_hit;
  logic [1:0]          commit_target;

  // An issue is only accepted when the addressed slot is free; a busy slot
  // simply stalls the ID stage, which holds the request.
  assign issue_ready_o = (state_q[issue_id_i] == ST_FREE);

  // The resolved state a commit handshake moves a slot into.
  assign commit_target = commit_kill_i ? ST_KILLED : ST_COMMITTED;

  // Per-slot next state and per-slot protocol-violation detection.
  always_comb begin
    issue_hit  = 1'b0;
    commit_hit = 1'b0;
    clear_hit  = 1'b0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      state_d[i]  = state_q[i];
      err_slot[i] = 1'b0;
      issue_hit   = issue_valid_i && (issue_id_i == X_ID_WIDTH'(i)) &&
                    (state_q[i] == ST_FREE);
      commit_hit  = commit_valid_i && (commit_id_i == X_ID_WIDTH'(i));
      clear_hit   = clear_i[i];
      case (state_q[i])
        ST_FREE: begin
          if (issue_hit) begin
            // A commit arriving together with the issue resolves the slot
            // straight away; the instruction never sits in ISSUED.
            state_d[i] = commit_hit ? commit_target : ST_ISSUED;
          end else if (commit_hit) begin
            err_slot[i] = 1'b1;
          end
          // Clearing a free slot is illegal; any accepted issue still lands.
          if (clear_hit) begin
            err_slot[i] = 1'b1;
          end
        end
        ST_ISSUED: begin
          if (commit_hit) begin
            state_d[i] = commit_target;
          end
          // WB must not retire an instruction that has not been resolved.
          if (clear_hit) begin
            err_slot[i] = 1'b1;
          end
        end
        default: begin
          // COMMITTED or KILLED: waiting for the WB clear.
          if (commit_hit) begin
            err_slot[i] = 1'b1;
          end
          if (clear_hit) begin
            state_d[i] = ST_FREE;
          end
        end
      endcase
    end
  end

  // Error flag is sticky until reset.
  assign err_d = err_q | (|err_slot);

  // Slot state registers; reset drops every in-flight ID at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < X_ID_MAX; i++) begin
        state_q[i] <= ST_FREE;
      end
    end else begin
      for (int i = 0; i < X_ID_MAX; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Sticky protocol-error register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Decode the registered slot states into the EX/WB vectors.
  always_comb begin
    wb_issue_o  = '0;
    wb_commit_o = '0;
    wb_kill_o   = '0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      wb_issue_o[i]  = (state_q[i] != ST_FREE);
      wb_commit_o[i] = (state_q[i] == ST_COMMITTED);
      wb_kill_o[i]   = (state_q[i] == ST_KILLED);
    end
  end

  // EX may retire exactly the committed IDs.
  assign ex_commit_o = wb_commit_o;

  // Count of occupied slots; X_ID_WIDTH+1 bits so a full table fits.
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      outstanding_o = outstanding_o + {{X_ID_WIDTH{1'b0}}, wb_issue_o[i]};
    end
  end

  assign busy_o = (outstanding_o != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed bench for the FIR XIFU ID scoreboard with a slot-level reference model.
module tb_fir_xifu_ctrl;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue_valid;
  logic [W-1:0] issue_id;
  logic         issue_ready;
  logic         commit_valid;
  logic [W-1:0] commit_id;
  logic         commit_kill;
  logic [N-1:0] clear;
  logic [N-1:0] ex_commit, wb_issue, wb_commit, wb_kill;
  logic         busy;
  logic [W:0]   outstanding;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: symbolic slot condition per ID.
  typedef enum int {M_FREE, M_ISSUED, M_COMMITTED, M_KILLED} mslot_t;
  mslot_t m_st [N];
  mslot_t m_ns [N];
  bit     m_err;
  bit     m_accept;

  fir_xifu_ctrl #(.X_ID_WIDTH(W), .X_ID_MAX(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_id_i     (issue_id),
    .issue_ready_o  (issue_ready),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .clear_i        (clear),
    .ex_commit_o    (ex_commit),
    .wb_issue_o     (wb_issue),
    .wb_commit_o    (wb_commit),
    .wb_kill_o      (wb_kill),
    .busy_o         (busy),
    .outstanding_o  (outstanding),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: apply the handshake rules to the slot table.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_st[i] = M_FREE;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) m_ns[i] = m_st[i];
      m_accept = issue_valid && (m_st[issue_id] == M_FREE);
      if (m_accept) m_ns[issue_id] = M_ISSUED;
      if (commit_valid) begin
        if (m_accept && commit_id == issue_id)
          m_ns[commit_id] = commit_kill ? M_KILLED : M_COMMITTED;
        else if (m_st[commit_id] == M_ISSUED)
          m_ns[commit_id] = commit_kill ? M_KILLED : M_COMMITTED;
        else
          m_err = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (clear[i]) begin
          if (m_st[i] == M_COMMITTED || m_st[i] == M_KILLED) m_ns[i] = M_FREE;
          else m_err = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) m_st[i] = m_ns[i];
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    logic [N-1:0] e_iss, e_com, e_kil;
    int cnt;
    e_iss = '0; e_com = '0; e_kil = '0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      e_iss[i] = (m_st[i] != M_FREE);
      e_com[i] = (m_st[i] == M_COMMITTED);
      e_kil[i] = (m_st[i] == M_KILLED);
      if (m_st[i] != M_FREE) cnt++;
    end
    chk("mdl_wb_issue",  32'(wb_issue),  32'(e_iss));
    chk("mdl_wb_commit", 32'(wb_commit), 32'(e_com));
    chk("mdl_ex_commit", 32'(ex_commit), 32'(e_com));
    chk("mdl_wb_kill",   32'(wb_kill),   32'(e_kil));
    chk("mdl_outstanding", 32'(outstanding), 32'(cnt));
    chk("mdl_busy", 32'(busy), 32'(cnt != 0));
    chk("mdl_err", 32'(err), 32'(m_err));
    chk("mdl_ready", 32'(issue_ready), 32'(m_st[issue_id] == M_FREE));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; commit_valid = 1'b0; commit_kill = 1'b0; clear = '0;
  endtask

  initial begin
    rst_n = 1'b0; issue_id = '0; commit_id = '0; idle();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_wb_issue", 32'(wb_issue), 32'h0);
    chk("reset_outstanding", 32'(outstanding), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    // Single issue / commit / clear of id 3
    issue_valid = 1'b1; issue_id = 4'd3; step(); idle();
    chk("iss3_wb_issue", 32'(wb_issue), 32'h0008);
    chk("iss3_outstanding", 32'(outstanding), 32'd1);
    chk("iss3_busy", 32'(busy), 32'd1);
    chk("iss3_ready", 32'(issue_ready), 32'd0);
    commit_valid = 1'b1; commit_id = 4'd3; step(); idle();
    chk("cmt3_ex_commit", 32'(ex_commit), 32'h0008);
    chk("cmt3_wb_commit", 32'(wb_commit), 32'h0008);
    clear = 16'h0008; step(); idle();
    chk("clr3_wb_issue", 32'(wb_issue), 32'h0);
    chk("clr3_wb_commit", 32'(wb_commit), 32'h0);
    chk("clr3_outstanding", 32'(outstanding), 32'd0);
    chk("clr3_ready", 32'(issue_ready), 32'd1);

    // Same-cycle issue and kill of id 5
    issue_valid = 1'b1; issue_id = 4'd5;
    commit_valid = 1'b1; commit_id = 4'd5; commit_kill = 1'b1;
    step(); idle();
    chk("ik5_wb_issue", 32'(wb_issue), 32'h0020);
    chk("ik5_wb_kill", 32'(wb_kill), 32'h0020);
    chk("ik5_ex_commit", 32'(ex_commit), 32'h0);
    chk("ik5_err", 32'(err), 32'h0);
    clear = 16'h0020; step(); idle();

    // Fill every slot, commit all, then bulk clear with a colliding issue
    for (int i = 0; i < N; i++) begin
      issue_valid = 1'b1; issue_id = W'(i); step();
    end
    idle();
    chk("full_outstanding", 32'(outstanding), 32'd16);
    for (int i = 0; i < N; i++) begin
      issue_id = W'(i); #1;
      chk("full_ready", 32'(issue_ready), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      commit_valid = 1'b1; commit_id = W'(i); step();
    end
    idle();
    chk("full_commit", 32'(wb_commit), 32'hFFFF);
    clear = 16'hFFFF; issue_valid = 1'b1; issue_id = 4'd4; #1;
    chk("bulk_ready4", 32'(issue_ready), 32'd0);
    step(); idle();
    chk("bulk_outstanding", 32'(outstanding), 32'd0);
    chk("bulk_wb_issue", 32'(wb_issue), 32'h0);

    // Concurrent events on distinct slots
    issue_valid = 1'b1; issue_id = 4'd0; step();
    issue_id = 4'd1; step(); idle();
    commit_valid = 1'b1; commit_id = 4'd1; step(); idle();
    issue_valid = 1'b1; issue_id = 4'd2;
    commit_valid = 1'b1; commit_id = 4'd0; commit_kill = 1'b1;
    clear = 16'h0002;
    step(); idle();
    chk("multi_wb_issue", 32'(wb_issue), 32'h0005);
    chk("multi_wb_kill", 32'(wb_kill), 32'h0001);
    chk("multi_err", 32'(err), 32'h0);
    commit_valid = 1'b1; commit_id = 4'd2; step(); idle();
    clear = 16'h0005; step(); idle();

    // Protocol errors
    commit_valid = 1'b1; commit_id = 4'd7; step(); idle();
    chk("err7_err", 32'(err), 32'd1);
    chk("err7_wb_issue", 32'(wb_issue), 32'h0);
    chk("err7_wb_commit", 32'(wb_commit), 32'h0);
    issue_valid = 1'b1; issue_id = 4'd1; step(); idle();
    clear = 16'h0002; step(); idle();
    chk("errclr_wb_issue", 32'(wb_issue), 32'h0002);
    chk("errclr_wb_commit", 32'(wb_commit), 32'h0);
    chk("errclr_err", 32'(err), 32'd1);

    // Asynchronous reset with six IDs in flight
    for (int i = 2; i < 7; i++) begin
      issue_valid = 1'b1; issue_id = W'(i); step();
    end
    idle();
    chk("pre_rst_outstanding", 32'(outstanding), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_issue", 32'(wb_issue), 32'h0);
    chk("arst_wb_commit", 32'(wb_commit), 32'h0);
    chk("arst_wb_kill", 32'(wb_kill), 32'h0);
    chk("arst_ex_commit", 32'(ex_commit), 32'h0);
    chk("arst_outstanding", 32'(outstanding), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
